// File: rtl/cic_decim_seq.sv
// Run-time sequencer for the IQ chain cic_decim -> cic_compfir: start/stop, flush, warm-up discard, rounding, statistics.
// Latency: input path 1 cycle (registered), CIC->FIR path 1 cycle (registered); o_dp_reset registered, aligned with o_state.
// Backpressure: the CIC cannot stall, so a CIC sample arriving while i_fir_ready is low is dropped and counted.
//
// Ports: i_clock/i_reset_n (async active-low), i_start/i_stop control pulses, i_inph/i_quad/i_valid ADC feed,
// o_cic_* to cic_decim, i_cic_* from cic_decim, o_fir_* to cic_compfir, i_fir_ready/i_fir_oflow from cic_compfir,
// o_state (IDLE=0 FLUSH=1 WARMUP=2 RUN=3 HALT=4), o_out_count/o_drop_count/o_oflow_count saturating statistics.
// Build option: define CIC_DECIM_SEQ_OFLOW_HALT_EN to make a FIR overflow in RUN park the chain in HALT until i_stop.
module cic_decim_seq #(
    parameter int IN_WIDTH     = 16,
    parameter int CIC_WIDTH    = 66,
    parameter int WARMUP_OUTS  = 5,
    parameter int FLUSH_CYCLES = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [IN_WIDTH-1:0]  i_inph,
    input  logic [IN_WIDTH-1:0]  i_quad,
    input  logic                 i_valid,
    output logic [CIC_WIDTH-1:0] o_cic_inph,
    output logic [CIC_WIDTH-1:0] o_cic_quad,
    output logic                 o_cic_valid,
    output logic                 o_dp_reset,
    input  logic [CIC_WIDTH-1:0] i_cic_inph,
    input  logic [CIC_WIDTH-1:0] i_cic_quad,
    input  logic                 i_cic_valid,
    output logic [IN_WIDTH-1:0]  o_fir_inph,
    output logic [IN_WIDTH-1:0]  o_fir_quad,
    output logic                 o_fir_valid,
    input  logic                 i_fir_ready,
    input  logic                 i_fir_oflow,
    output logic [2:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_out_count,
    output logic [CNT_WIDTH-1:0] o_drop_count,
    output logic [CNT_WIDTH-1:0] o_oflow_count
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int WW = $clog2(WARMUP_OUTS + 1);
    localparam int SW = CIC_WIDTH - IN_WIDTH - 1;   // CIC LSBs below the rounding point

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        WARMUP = 3'd2,
        RUN    = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t          state, next_state;
    logic [FW-1:0]   flush_cnt;
    logic [WW-1:0]   warm_cnt;
    logic            warm_done;
    logic            in_fwd, fir_fwd, clr_stats;
    logic [IN_WIDTH-1:0] rnd_inph, rnd_quad;

    // Bits below the rounding point carry no information for the FIR.
    logic unused_lsbs;
    assign unused_lsbs = ^{i_cic_inph[SW-1:0], i_cic_quad[SW-1:0]};

    // (r+1)>>>1 written as floor(r/2) + lsb so no carry bit is lost; the only
    // overflowing input is max positive, which saturates.
    function automatic logic [IN_WIDTH-1:0] round_half(input logic [IN_WIDTH:0] r);
        if (r == {1'b0, {IN_WIDTH{1'b1}}})
            return {1'b0, {(IN_WIDTH-1){1'b1}}};
        return r[IN_WIDTH:1] + {{(IN_WIDTH-1){1'b0}}, r[0]};
    endfunction

    assign rnd_inph = round_half(i_cic_inph[CIC_WIDTH-1 -: IN_WIDTH+1]);
    assign rnd_quad = round_half(i_cic_quad[CIC_WIDTH-1 -: IN_WIDTH+1]);

    assign warm_done = (WARMUP_OUTS == 0) ||
                       (i_cic_valid && (warm_cnt == WW'(WARMUP_OUTS - 1)));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (i_start) next_state = FLUSH;
            FLUSH:  if (flush_cnt == FW'(FLUSH_CYCLES - 1)) next_state = WARMUP;
            WARMUP: if (warm_done) next_state = RUN;
            RUN: begin
`ifdef CIC_DECIM_SEQ_OFLOW_HALT_EN
                if (i_fir_oflow) next_state = HALT;
`endif
            end
            HALT:   next_state = HALT;
            default: next_state = IDLE;
        endcase
        // Stop overrides everything, including a simultaneous start.
        if (i_stop) next_state = IDLE;
    end

    // Forwarding is qualified by the next state too, so a stop (or halt) in
    // the same cycle as a sample leaves no strobe behind in IDLE/HALT.
    assign in_fwd    = (state == WARMUP || state == RUN) &&
                       (next_state == WARMUP || next_state == RUN);
    assign fir_fwd   = (state == RUN) && (next_state == RUN) && i_cic_valid && i_fir_ready;
    assign clr_stats = (state == IDLE) && (next_state == FLUSH);
    assign o_state   = state;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            warm_cnt   <= '0;
            o_dp_reset <= 1'b1;
        end else begin
            state      <= next_state;
            o_dp_reset <= !(next_state == WARMUP || next_state == RUN);
            flush_cnt  <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
            if (state != WARMUP)
                warm_cnt <= '0;
            else if (i_cic_valid)
                warm_cnt <= warm_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_cic_valid <= 1'b0;
            o_cic_inph  <= '0;
            o_cic_quad  <= '0;
            o_fir_valid <= 1'b0;
            o_fir_inph  <= '0;
            o_fir_quad  <= '0;
        end else begin
            o_cic_valid <= i_valid && in_fwd;
            if (i_valid) begin
                o_cic_inph <= {{(CIC_WIDTH-IN_WIDTH){i_inph[IN_WIDTH-1]}}, i_inph};
                o_cic_quad <= {{(CIC_WIDTH-IN_WIDTH){i_quad[IN_WIDTH-1]}}, i_quad};
            end
            o_fir_valid <= fir_fwd;
            if (fir_fwd) begin
                o_fir_inph <= rnd_inph;
                o_fir_quad <= rnd_quad;
            end
        end
    end

    // Statistics: cleared on entry to FLUSH, saturate at all-ones.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_out_count   <= '0;
            o_drop_count  <= '0;
            o_oflow_count <= '0;
        end else if (clr_stats) begin
            o_out_count   <= '0;
            o_drop_count  <= '0;
            o_oflow_count <= '0;
        end else begin
            if (fir_fwd && !(&o_out_count))
                o_out_count <= o_out_count + 1'b1;
            if ((state == RUN) && i_cic_valid && !i_fir_ready && !(&o_drop_count))
                o_drop_count <= o_drop_count + 1'b1;
            if ((state == RUN) && i_fir_oflow && !(&o_oflow_count))
                o_oflow_count <= o_oflow_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cic_decim_seq.sv
// Directed bench for cic_decim_seq: reset/idle, start/flush timing, warm-up discard,
// rounding corners, drop policing, stop-kill and overflow handling.
// Build option: CIC_DECIM_SEQ_OFLOW_HALT_EN selects the HALT expectations.
module tb_cic_decim_seq;
    localparam int IW = 16;
    localparam int CW = 66;
    localparam int SH = CW - IW - 1;

    logic          i_clock = 1'b0;
    logic          i_reset_n;
    logic          i_start, i_stop, i_valid;
    logic [IW-1:0] i_inph, i_quad;
    logic [CW-1:0] o_cic_inph, o_cic_quad;
    logic          o_cic_valid, o_dp_reset;
    logic [CW-1:0] i_cic_inph, i_cic_quad;
    logic          i_cic_valid;
    logic [IW-1:0] o_fir_inph, o_fir_quad;
    logic          o_fir_valid, i_fir_ready, i_fir_oflow;
    logic [2:0]    o_state;
    logic [31:0]   o_out_count, o_drop_count, o_oflow_count;

    int n_checks = 0;
    int n_fail   = 0;
    int fir_total = 0;
    int cic_total = 0;

    cic_decim_seq dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_start(i_start), .i_stop(i_stop),
        .i_inph(i_inph), .i_quad(i_quad), .i_valid(i_valid),
        .o_cic_inph(o_cic_inph), .o_cic_quad(o_cic_quad), .o_cic_valid(o_cic_valid),
        .o_dp_reset(o_dp_reset),
        .i_cic_inph(i_cic_inph), .i_cic_quad(i_cic_quad), .i_cic_valid(i_cic_valid),
        .o_fir_inph(o_fir_inph), .o_fir_quad(o_fir_quad), .o_fir_valid(o_fir_valid),
        .i_fir_ready(i_fir_ready), .i_fir_oflow(i_fir_oflow),
        .o_state(o_state),
        .o_out_count(o_out_count), .o_drop_count(o_drop_count), .o_oflow_count(o_oflow_count)
    );

    initial forever #5 i_clock = ~i_clock;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge i_clock) begin
        if (o_fir_valid === 1'b1) fir_total++;
        if (o_cic_valid === 1'b1) cic_total++;
    end

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_clock);
            #1;
        end
    endtask

    task automatic strobe(input logic [CW-1:0] ci, input logic [CW-1:0] cq, input logic rdy);
        i_cic_inph  = ci;
        i_cic_quad  = cq;
        i_cic_valid = 1'b1;
        i_fir_ready = rdy;
        step();
        i_cic_valid = 1'b0;
    endtask

    // Start the chain, optionally pulse overflow during FLUSH, then warm up into RUN.
    task automatic run_to_run(input bit oflow_in_flush);
        int g;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("clr_out", o_out_count, 0);
        check("clr_drop", o_drop_count, 0);
        if (oflow_in_flush) begin
            i_fir_oflow = 1'b1;
            step();
            i_fir_oflow = 1'b0;
        end
        g = 0;
        while (o_state != 3'd2 && g < 100) begin
            step();
            g++;
        end
        check("reach_warmup", o_state, 2);
        repeat (5) strobe('0, '0, 1'b1);
        check("reach_run", o_state, 3);
        check("oflow_outside_run", o_oflow_count, 0);
    endtask

    initial begin
        int n, g, bf, bc;
        logic rdy;
        i_reset_n = 1'b0;
        i_start = 0; i_stop = 0; i_valid = 0; i_inph = '0; i_quad = '0;
        i_cic_inph = '0; i_cic_quad = '0; i_cic_valid = 0;
        i_fir_ready = 0; i_fir_oflow = 0;
        step(3);
        i_reset_n = 1'b1;
        check("rst_state", o_state, 0);
        check("rst_dp_reset", o_dp_reset, 1);
        check("rst_cic_valid", o_cic_valid, 0);
        check("rst_fir_valid", o_fir_valid, 0);
        check("rst_out_cnt", o_out_count, 0);
        check("rst_drop_cnt", o_drop_count, 0);
        check("rst_oflow_cnt", o_oflow_count, 0);
        check("rst_fir_data", o_fir_inph, 0);
        check("rst_cic_data", o_cic_inph, 0);

        // Idle with hostile inputs: nothing may be forwarded or counted.
        bf = fir_total; bc = cic_total;
        i_valid = 1; i_cic_valid = 1; i_fir_ready = 1; i_fir_oflow = 1;
        step(1000);
        i_valid = 0; i_cic_valid = 0; i_fir_oflow = 0;
        check("idle_state", o_state, 0);
        check("idle_dp_reset", o_dp_reset, 1);
        check("idle_cic_strobes", cic_total - bc, 0);
        check("idle_fir_strobes", fir_total - bf, 0);
        check("idle_oflow_cnt", o_oflow_count, 0);

        // Start and stop together: stop wins.
        i_start = 1; i_stop = 1;
        step();
        i_start = 0; i_stop = 0;
        check("start_stop_state", o_state, 0);
        step();
        check("start_stop_state2", o_state, 0);

        // Start: FLUSH with datapath reset for exactly 16 cycles, then WARMUP.
        i_start = 1;
        step();
        i_start = 0;
        check("flush_entry", o_state, 1);
        n = 0; g = 0;
        while (o_state == 3'd1 && g < 100) begin
            if (o_dp_reset) n++;
            step();
            g++;
        end
        check("flush_len", n, 16);
        check("warmup_state", o_state, 2);
        check("warmup_dp_reset", o_dp_reset, 0);

        // Input path: sign extension, 1-cycle latency.
        i_valid = 1; i_inph = 16'hFFFB; i_quad = 16'h0007;
        step();
        i_valid = 0;
        check("in_valid", o_cic_valid, 1);
        check("in_inph_sext", o_cic_inph, 66'h3FFFFFFFFFFFFFFFB);
        check("in_quad", o_cic_quad, 66'h7);
        step();
        check("in_valid_drop", o_cic_valid, 0);

        // 45 CIC strobes: 5 discarded, 40 forwarded.  top17 3 -> 2, 1FFFD -> FFFF.
        bf = fir_total;
        for (int i = 0; i < 45; i++) begin
            strobe({17'h00003, 49'd0} | CW'(i), {17'h1FFFD, 49'd0}, 1'b1);
            if (i == 3) check("warm_still", o_state, 2);
            if (i == 4) check("warm_to_run", o_state, 3);
        end
        step(2);
        check("stream_strobes", fir_total - bf, 40);
        check("stream_out_cnt", o_out_count, 40);
        check("stream_drop_cnt", o_drop_count, 0);
        check("round_pos3", o_fir_inph, 16'h0002);
        check("round_neg3", o_fir_quad, 16'hFFFF);
        check("fir_valid_idle", o_fir_valid, 0);

        // Rounding corners.
        strobe({17'h0FFFF, 49'h0ABCD}, {17'h1FFFF, 49'd0}, 1'b1);
        check("sat_valid", o_fir_valid, 1);
        check("round_sat", o_fir_inph, 16'h7FFF);
        check("round_neg1", o_fir_quad, 16'h0000);
        strobe({17'h10000, 49'd0}, {17'h0FFFE, 49'd0}, 1'b1);
        check("round_minneg", o_fir_inph, 16'h8000);
        check("round_even_max", o_fir_quad, 16'h7FFF);
        check("corner_out_cnt", o_out_count, 42);

        i_stop = 1;
        step();
        i_stop = 0;
        check("stop_state", o_state, 0);
        check("stop_holds_cnt", o_out_count, 42);

        // Restart (counters clear), overflow during FLUSH must not count, then drops.
        run_to_run(1'b1);
        bf = fir_total;
        for (int i = 0; i < 10; i++) begin
            rdy = (i % 3 != 2);
            strobe({17'(i + 1), 49'd0}, '0, rdy);
            check("drop_valid", o_fir_valid, rdy);
            if (rdy) check("drop_data", o_fir_inph, 16'((i + 2) / 2));
        end
        step();
        check("drop_cnt", o_drop_count, 3);
        check("drop_out_cnt", o_out_count, 7);
        check("drop_strobes", fir_total - bf, 7);

        // Stop mid-stream: no strobe at all once IDLE is entered.
        i_valid = 1; i_cic_valid = 1; i_fir_ready = 1;
        step(3);
        i_stop = 1;
        step();
        i_stop = 0;
        bf = fir_total; bc = cic_total;
        check("kill_state", o_state, 0);
        check("kill_dp_reset", o_dp_reset, 1);
        check("kill_fir_valid", o_fir_valid, 0);
        check("kill_cic_valid", o_cic_valid, 0);
        step(20);
        check("kill_fir_strobes", fir_total - bf, 0);
        check("kill_cic_strobes", cic_total - bc, 0);
        i_valid = 0; i_cic_valid = 0;

        // Overflow in RUN.
        run_to_run(1'b0);
        i_fir_oflow = 1;
        step();
        i_fir_oflow = 0;
        check("oflow_cnt", o_oflow_count, 1);
`ifdef CIC_DECIM_SEQ_OFLOW_HALT_EN
        check("halt_state", o_state, 4);
        check("halt_dp_reset", o_dp_reset, 1);
        bf = fir_total;
        repeat (3) strobe('0, '0, 1'b1);
        step();
        check("halt_no_fwd", fir_total - bf, 0);
        check("halt_sticky", o_state, 4);
        i_stop = 1;
        step();
        i_stop = 0;
        check("halt_stop", o_state, 0);
`else
        check("oflow_run_state", o_state, 3);
        check("oflow_dp_reset", o_dp_reset, 0);
        strobe('0, '0, 1'b1);
        check("oflow_still_fwd", o_fir_valid, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
